rmul_pipe_approx: RTL and testbench
===================================

// Module: rmul_pipe_approx
// PURPOSE
//  Parametrised, pipelined, recursive 2x2-leaf unsigned multiplier with per-transaction accuracy mode.
//  Operands split into 2-bit digits; (W/2)^2 leaf products summed at weight 4^(i+j).
//  Replaces the fixed combinational 8x8 quadrant multipliers in accelerator datapaths.
//  Valid/ready on both sides; fixed 3-cycle latency when not stalled.
// PARAMETERS
//  W        8   operand width; even, 4..32
//  CNT_W    32  width of completed-transaction counter
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands/mode valid
//  in_ready   out  1        block accepts this cycle
//  in_a       in   W        unsigned multiplicand
//  in_b       in   W        unsigned multiplier
//  in_mode    in   2        00 exact; 01 approx quadrant LL; 10 approx LL,LH,HL; 11 approx all
//  out_valid  out  1        product valid
//  out_ready  in   1        downstream accepts
//  out_p      out  2W       product
//  out_mode   out  2        mode travelling with product
//  done_cnt   out  CNT_W    count of products accepted downstream
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids 0, out_valid=0, out_p=0, out_mode=0, done_cnt=0.
//  - Leaf: exact 2x2 (HA-based); approximate leaf identical except 3*3 -> 4'b0111 (error -2).
//  - Quadrant = top-level split of A and B into W/2 halves (LL=A_L*B_L, LH=A_H*B_L, HL=A_L*B_H, HH).
//    A leaf is approximate iff its quadrant is selected by in_mode.
//  - Pipeline: S1 registers leaf products + mode; S2 registers 4 quadrant sums (W bits each);
//    S3 registers out_p = HH<<W + (LH+HL)<<(W/2) + LL, full 2W width, no truncation.
//  - Global advance en = !out_valid | out_ready; in_ready = en (combinational, no in_valid dependence).
//  - Transfer at input when in_valid & in_ready; at output when out_valid & out_ready.
//  - Stall: when en=0 every stage holds data and valid; out_p/out_mode stable while out_valid & !out_ready.
//  - Bubbles propagate as valid=0; data regs of invalid stages may update (don't care) but out_p
//    holds its last value when out_valid=0.
//  - Latency: input transfer in cycle t -> out_valid in cycle t+3 if en held high; throughput 1/cycle.
//  - Simultaneous output transfer and new input: both occur, no bubble inserted.
//  - done_cnt increments by 1 on each output transfer; wraps at 2^CNT_W modulo.
//  - rst_n low mid-operation: all in-flight products discarded immediately; none emitted after release.
//  - Mode sampled with operands; changing in_mode never affects in-flight transactions.
// STRUCTURE
//  - Shared package rmul_pkg: MODE_EXACT/MODE_LL/MODE_LOW3/MODE_ALL constants,
//    function leaf_mul(a2,b2,approx) returning 4 bits, quadrant index constants.
//  - One sub-module: rmul_leaf2x2 (a[1:0], b[1:0], approx -> p[3:0]), instantiated (W/2)^2 via generate.
//  - Rest is one file: generate loops for leaves, quadrant adders, pipeline regs, counter.
// TESTING (W=8)
//  - A=0xFF,B=0xFF,mode=00, out_ready=1 -> out_p=0xFE01 exactly 3 cycles after accept.
//  - Same operands mode=11 -> 0xC58F; mode=01 -> 0xFDCF; mode=10 -> 0xF78F.
//  - A=0x00,B=0xB7, all modes -> 0x0000; A=0x12,B=0x34 mode=00 -> 0x03A8.
//  - Back-to-back 4 inputs, out_ready low cycles 2-5 -> in_ready low while out_valid held,
//    out_p stable, all 4 results emitted in order, done_cnt=4.
//  - rst_n pulsed low with 3 in flight -> out_valid=0, done_cnt=0, no stale output after release.
//  - Random 10k vectors vs reference model (exact/approx leaf formula), including random
//    out_ready stall patterns; zero mismatches, done_cnt equals accepted count.

Source files
------------

// File: rtl/rmul_pkg.sv
// Shared definitions for the recursive 2x2-leaf multiplier: accuracy modes,
// quadrant indices and the exact/approximate leaf product.
package rmul_pkg;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_LL    = 2'b01;
  localparam logic [1:0] MODE_LOW3  = 2'b10;
  localparam logic [1:0] MODE_ALL   = 2'b11;

  localparam int Q_LL  = 0;
  localparam int Q_LH  = 1;
  localparam int Q_HL  = 2;
  localparam int Q_HH  = 3;
  localparam int NUM_Q = 4;

  function automatic logic [3:0] leaf_mul(
    input logic [1:0] a2,
    input logic [1:0] b2,
    input logic       approx
  );
    logic pp0, pp1, pp2, pp3, c1, c1_kept;
    pp0 = a2[0] & b2[0];
    pp1 = a2[1] & b2[0];
    pp2 = a2[0] & b2[1];
    pp3 = a2[1] & b2[1];
    c1  = pp1 & pp2;
    // Only 3*3 produces the middle carry; the approximate leaf drops it and sets bit 1 instead (9 -> 7).
    c1_kept = c1 & ~approx;
    return {pp3 & c1_kept, pp3 ^ c1_kept, (pp1 ^ pp2) | (c1 & approx), pp0};
  endfunction

  function automatic logic quad_approx(input logic [1:0] mode, input int q);
    logic sel;
    case (mode)
      MODE_EXACT: sel = 1'b0;
      MODE_LL:    sel = (q == Q_LL);
      MODE_LOW3:  sel = (q != Q_HH);
      MODE_ALL:   sel = 1'b1;
      default:    sel = 1'b1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rmul_leaf2x2.sv
// 2x2 unsigned leaf multiplier; approximate variant maps 3*3 to 7.
module rmul_leaf2x2
  import rmul_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       approx,
  output logic [3:0] p
);

  assign p = leaf_mul(a, b, approx);

endmodule

// File: rtl/rmul_pipe_approx.sv
// Three-stage pipelined unsigned multiplier built from 2x2 leaves, with a
// per-transaction accuracy mode selecting which quadrants use approximate leaves.
module rmul_pipe_approx
  import rmul_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int H  = W / 2;
  localparam int D  = (H + 1) / 2;   // 2-bit digits per half, odd halves zero-padded
  localparam int HP = 2 * D;
  localparam int PW = 2 * W;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [HP-1:0]      qa [NUM_Q];
  logic [HP-1:0]      qb [NUM_Q];
  logic [NUM_Q-1:0]   quad_sel;
  logic [3:0]         leaf_p [NUM_Q][D][D];

  always_comb begin
    qa[Q_LL] = HP'(in_a[H-1:0]);
    qb[Q_LL] = HP'(in_b[H-1:0]);
    qa[Q_LH] = HP'(in_a[W-1:H]);
    qb[Q_LH] = HP'(in_b[H-1:0]);
    qa[Q_HL] = HP'(in_a[H-1:0]);
    qb[Q_HL] = HP'(in_b[W-1:H]);
    qa[Q_HH] = HP'(in_a[W-1:H]);
    qb[Q_HH] = HP'(in_b[W-1:H]);
  end

  for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_quad
    assign quad_sel[gi] = quad_approx(in_mode, gi);
    for (genvar gj = 0; gj < D; gj++) begin : g_adig
      for (genvar gk = 0; gk < D; gk++) begin : g_bdig
        rmul_leaf2x2 u_leaf (
          .a      (qa[gi][2*gj +: 2]),
          .b      (qb[gi][2*gk +: 2]),
          .approx (quad_sel[gi]),
          .p      (leaf_p[gi][gj][gk])
        );
      end
    end
  end

  logic             s1_valid_reg;
  logic [1:0]       s1_mode_reg;
  logic [3:0]       s1_leaf_reg [NUM_Q][D][D];
  logic             s2_valid_reg;
  logic [1:0]       s2_mode_reg;
  logic [W-1:0]     s2_quad_reg [NUM_Q];
  logic [W-1:0]     quad_sum [NUM_Q];
  logic [PW-1:0]    prod_next;

  // Sums wrap modulo 2^W; the true quadrant product always fits, so the result is exact.
  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      quad_sum[q] = '0;
      for (int i = 0; i < D; i++) begin
        for (int j = 0; j < D; j++) begin
          quad_sum[q] = quad_sum[q] + (W'(s1_leaf_reg[q][i][j]) << (2 * (i + j)));
        end
      end
    end
  end

  assign prod_next = (PW'(s2_quad_reg[Q_HH]) << W)
                   + ((PW'(s2_quad_reg[Q_LH]) + PW'(s2_quad_reg[Q_HL])) << H)
                   + PW'(s2_quad_reg[Q_LL]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
      out_p        <= '0;
      out_mode     <= '0;
      done_cnt     <= '0;
    end else begin
      if (en) begin
        s1_valid_reg <= in_valid;
        s2_valid_reg <= s1_valid_reg;
        out_valid    <= s2_valid_reg;
        if (s2_valid_reg) begin
          out_p    <= prod_next;
          out_mode <= s2_mode_reg;
        end
      end
      if (out_valid && out_ready) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

  // Intermediate data only matters alongside its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_mode_reg <= in_mode;
      s1_leaf_reg <= leaf_p;
      s2_mode_reg <= s1_mode_reg;
      s2_quad_reg <= quad_sum;
    end
  end

endmodule

// File: tb/tb_rmul_pipe_approx.sv
// Scoreboard bench for rmul_pipe_approx: directed spot values, stall, reset
// and random traffic checked against an arithmetic reference model.
module tb_rmul_pipe_approx;

  localparam int W     = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [1:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [2*W-1:0]   out_p;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] done_cnt;

  rmul_pipe_approx #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_mode  (out_mode),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [1:0]     mode;
    logic [2*W-1:0] p;
  } exp_t;

  exp_t           sb[$];
  exp_t           head;
  logic [2*W-1:0] cur_exp = '0;
  int             checks = 0;
  int             errors = 0;
  int             xfer_out = 0;
  int             acc_in = 0;
  int             stall_cycles = 0;
  int             txn = 0;
  bit             rand_ready = 1'b0;
  bit             prev_hold = 1'b0;
  logic [2*W-1:0] prev_p;
  logic [1:0]     prev_mode;

  // Exact product minus 2*4^(i+j) for every digit pair (3,3) whose quadrant the mode makes approximate.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] mode);
    int  p, da, db;
    bit  hi_a, hi_b, sel;
    p = int'(a) * int'(b);
    for (int i = 0; i < W/2; i++) begin
      for (int j = 0; j < W/2; j++) begin
        da   = (int'(a) >> (2*i)) & 3;
        db   = (int'(b) >> (2*j)) & 3;
        hi_a = (i >= W/4);
        hi_b = (j >= W/4);
        case (mode)
          2'd0:    sel = 1'b0;
          2'd1:    sel = !hi_a && !hi_b;
          2'd2:    sel = !(hi_a && hi_b);
          default: sel = 1'b1;
        endcase
        if (sel && da == 3 && db == 3) p = p - (2 << (2*(i+j)));
      end
    end
    return (2*W)'(p);
  endfunction

  always begin
    @(negedge clk);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: samples between edges, predicting the transfers at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        checks++;
        if (done_cnt !== CNT_W'(xfer_out)) begin
          errors++;
          $display("FAIL done_cnt: got %0d want %0d", done_cnt, xfer_out);
        end
        if (prev_hold) begin
          checks++;
          if (out_valid !== 1'b1 || out_p !== prev_p || out_mode !== prev_mode) begin
            errors++;
            $display("FAIL stall_hold: got v=%b p=%h m=%0d want v=1 p=%h m=%0d",
                     out_valid, out_p, out_mode, prev_p, prev_mode);
          end
        end
        if (out_valid && !out_ready) begin
          stall_cycles++;
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_stall: got %b want 0", in_ready);
          end
        end
        if (!out_valid) begin
          checks++;
          if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_idle: got %b want 1", in_ready);
          end
        end
        if (in_valid && in_ready) begin
          sb.push_back('{a: in_a, b: in_b, mode: in_mode, p: cur_exp});
          acc_in++;
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got p=%h m=%0d want no output", out_p, out_mode);
          end else begin
            head = sb.pop_front();
            txn++;
            $display("txn %0d a=%h b=%h mode=%0d p=%h exp=%h", txn, head.a, head.b,
                     head.mode, out_p, head.p);
            if (out_p !== head.p || out_mode !== head.mode) begin
              errors++;
              $display("FAIL product: got p=%h m=%0d want p=%h m=%0d",
                       out_p, out_mode, head.p, head.mode);
            end
          end
          xfer_out++;
        end
        prev_hold = out_valid && !out_ready;
        prev_p    = out_p;
        prev_mode = out_mode;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] mode, input logic [2*W-1:0] exp_p);
    int waited;
    bit rdy;
    waited   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    cur_exp  = exp_p;
    forever begin
      #3;
      rdy = in_ready;
      @(negedge clk);
      if (rdy) break;
      waited++;
      if (waited > 1000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no in_ready want accept within 1000 cycles");
        break;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic pulse_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    xfer_out = 0;
    acc_in   = 0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (done_cnt !== '0)    begin errors++; $display("FAIL rst_done_cnt: got %0d want 0", done_cnt); end
    if (out_p !== '0)       begin errors++; $display("FAIL rst_out_p: got %h want 0", out_p); end
    if (out_mode !== '0)    begin errors++; $display("FAIL rst_out_mode: got %0d want 0", out_mode); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    logic [1:0]   rm;

    @(negedge clk);
    pulse_reset();

    // Latency of a single transaction into an empty pipeline.
    send(8'hFF, 8'hFF, 2'b00, 16'hFE01);
    in_valid = 1'b0;
    lat = 1;
    forever begin
      #3;
      if (out_valid || lat >= 10) break;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL latency: got %0d want 3", lat);
    end
    drain();

    send(8'hFF, 8'hFF, 2'b11, 16'hC58F);
    send(8'hFF, 8'hFF, 2'b01, 16'hFDCF);
    send(8'hFF, 8'hFF, 2'b10, 16'hF78F);
    for (int m = 0; m < 4; m++) send(8'h00, 8'hB7, 2'(m), 16'h0000);
    send(8'h12, 8'h34, 2'b00, 16'h03A8);
    in_valid = 1'b0;
    drain();

    // Output stalled while four back-to-back inputs are offered.
    pulse_reset();
    stall_cycles = 0;
    out_ready = 1'b0;
    fork
      begin
        send(8'h12, 8'h34, 2'b00, 16'h03A8);
        send(8'hFF, 8'hFF, 2'b11, 16'hC58F);
        send(8'hFF, 8'hFF, 2'b01, 16'hFDCF);
        send(8'hFF, 8'hFF, 2'b10, 16'hF78F);
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    checks += 2;
    if (done_cnt !== 32'd4) begin
      errors++;
      $display("FAIL stall_done_cnt: got %0d want 4", done_cnt);
    end
    if (stall_cycles < 1) begin
      errors++;
      $display("FAIL stall_seen: got %0d stalled cycles want >=1", stall_cycles);
    end

    // Reset with three products in flight; nothing may emerge afterwards.
    out_ready = 1'b1;
    send(8'h21, 8'h43, 2'b00, ref_mul(8'h21, 8'h43, 2'b00));
    send(8'hF3, 8'h3F, 2'b11, ref_mul(8'hF3, 8'h3F, 2'b11));
    send(8'h77, 8'hEE, 2'b10, ref_mul(8'h77, 8'hEE, 2'b10));
    pulse_reset();
    repeat (8) @(negedge clk);

    // Random traffic with random downstream back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 2) == 0) ra = ra | W'($urandom);
      if ($urandom_range(0, 2) == 0) rb = rb | W'($urandom);
      rm = 2'($urandom_range(0, 3));
      send(ra, rb, rm, ref_mul(ra, rb, rm));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();
    checks++;
    if (done_cnt !== CNT_W'(acc_in)) begin
      errors++;
      $display("FAIL random_done_cnt: got %0d want %0d", done_cnt, acc_in);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
